// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte handshake, status and PS/2 line bundle.
// master = byte source + line model, slave = ps2_host_tx.
interface ps2_host_tx_if;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic [1:0] status;

  modport master (
    output ps2_clk_in,
    output ps2_data_in,
    output tx_data,
    output tx_valid,
    input  ps2_clk_oe,
    input  ps2_data_oe,
    input  tx_ready,
    input  busy,
    input  done,
    input  status
  );

  modport slave (
    input  ps2_clk_in,
    input  ps2_data_in,
    input  tx_data,
    input  tx_valid,
    output ps2_clk_oe,
    output ps2_data_oe,
    output tx_ready,
    output busy,
    output done,
    output status
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command byte transmitter.
// Ports: clk, reset (async, high), bus (ps2_host_tx_if.slave):
//   ps2_clk_in/ps2_data_in raw lines, ps2_clk_oe/ps2_data_oe
//   pull-low enables, tx_data/tx_valid/tx_ready byte handshake,
//   busy, done pulse, status (00 ack, 01 timeout, 10 no ack).
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ    = 25_000_000,
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375_000
) (
  input logic         clk,
  input logic         reset,
  ps2_host_tx_if.slave bus
);

  // A zero inhibit length falls back to 100 us of clk.
  localparam int INH =
    (INHIBIT_CYCLES > 0) ? INHIBIT_CYCLES
                         : (CLK_FREQ_HZ / 10_000);
  localparam int IW = $clog2(INH + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INH - 1);
  localparam logic [WW-1:0] WD_LAST  =
    WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQUEST,
    S_SEND,
    S_ACK,
    S_WAIT
  } state_t;

  state_t        r_state;
  logic [2:0]    r_clk_sync;
  logic [2:0]    r_dat_sync;
  logic [7:0]    r_byte;
  logic [3:0]    r_bit_cnt;
  logic [IW-1:0] r_inh_cnt;
  logic [WW-1:0] r_wd_cnt;
  logic          r_nack;
  logic          r_clk_oe;
  logic          r_data_oe;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;
  logic [1:0]    r_status;

  logic w_fall;
  logic w_din;
  logic w_lines_idle;
  logic w_parity;
  logic w_next_bit;
  logic w_counting;
  logic w_wd_exp;

  assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_din  = r_dat_sync[1];
  // Both lines must read high on two consecutive samples.
  assign w_lines_idle = (&r_clk_sync[2:1])
                      & (&r_dat_sync[2:1]);
  assign w_parity = ~^r_byte;
  assign w_next_bit = (r_bit_cnt == 4'd8)
                    ? w_parity
                    : r_byte[r_bit_cnt[2:0]];
  assign w_counting = (r_state == S_SEND)
                    | (r_state == S_ACK)
                    | (r_state == S_WAIT);
  assign w_wd_exp = (r_wd_cnt == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_clk_sync <= 3'b111;
      r_dat_sync <= 3'b111;
      r_byte     <= '0;
      r_bit_cnt  <= '0;
      r_inh_cnt  <= '0;
      r_wd_cnt   <= '0;
      r_nack     <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_status   <= 2'b00;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], bus.ps2_clk_in};
      r_dat_sync <= {r_dat_sync[1:0], bus.ps2_data_in};
      r_done     <= 1'b0;
      // Watchdog wins over any edge seen in the same cycle.
      if (w_counting && w_wd_exp) begin
        r_clk_oe  <= 1'b0;
        r_data_oe <= 1'b0;
        r_done    <= 1'b1;
        r_status  <= 2'b01;
        r_wd_cnt  <= '0;
        r_state   <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            // busy/ready settle one cycle after done.
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            if (bus.tx_valid && r_ready) begin
              r_byte    <= bus.tx_data;
              r_busy    <= 1'b1;
              r_ready   <= 1'b0;
              r_clk_oe  <= 1'b1;
              r_inh_cnt <= '0;
              r_state   <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (r_inh_cnt == INH_LAST) begin
              r_data_oe <= 1'b1;
              r_wd_cnt  <= '0;
              r_state   <= S_REQUEST;
            end else begin
              r_inh_cnt <= r_inh_cnt + 1'b1;
            end
          end
          S_REQUEST: begin
            r_clk_oe  <= 1'b0;
            r_bit_cnt <= '0;
            r_state   <= S_SEND;
          end
          S_SEND: begin
            if (w_fall) begin
              r_wd_cnt  <= '0;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == 4'd9) begin
                r_data_oe <= 1'b0;
                r_state   <= S_ACK;
              end else begin
                r_data_oe <= ~w_next_bit;
              end
            end else begin
              r_wd_cnt <= r_wd_cnt + 1'b1;
            end
          end
          S_ACK: begin
            if (w_fall) begin
              r_wd_cnt <= '0;
              r_nack   <= w_din;
              r_state  <= S_WAIT;
            end else begin
              r_wd_cnt <= r_wd_cnt + 1'b1;
            end
          end
          S_WAIT: begin
            if (w_lines_idle) begin
              r_done   <= 1'b1;
              r_status <= {r_nack, 1'b0};
              r_state  <= S_IDLE;
            end else if (w_fall) begin
              r_wd_cnt <= '0;
            end else begin
              r_wd_cnt <= r_wd_cnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.ps2_clk_oe  = r_clk_oe;
  assign bus.ps2_data_oe = r_data_oe;
  assign bus.tx_ready    = r_ready;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.status      = r_status;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset), using the standard host request-to-send sequence. It sits beside the PS/2 keyboard receiver on the same open-drain clock and data lines. While a transfer is in progress, `busy` tells that receiver to ignore line activity.

## Interface
- `CLK_FREQ_HZ`, default 25_000_000: system clock frequency.
- `INHIBIT_CYCLES`, default 2500: clock-inhibit duration in clk cycles (100 µs at 25 MHz).
- `TIMEOUT_CYCLES`, default 375_000: watchdog limit in clk cycles (15 ms).

Ports:
- `clk`  in  1: system clock. This is the only clock.
- `reset`  in  1: asynchronous, active-high reset.
- `ps2_clk_in`  in  1: raw PS/2 clock line level.
- `ps2_data_in`  in  1: raw PS/2 data line level.
- `ps2_clk_oe`  out  1: 1 drives the PS/2 clock line low; 0 releases it.
- `ps2_data_oe`  out  1: 1 drives the PS/2 data line low; 0 releases it.
- `tx_data`  in  8: command byte to send.
- `tx_valid`  in  1: a byte is offered.
- `tx_ready`  out  1: the block can accept a byte.
- `busy`  out  1: a transfer is in progress.
- `done`  out  1: one-cycle completion pulse.
- `status`  out  2: result of the last transfer. 00 = acked, 01 = timeout, 10 = no ack. Held until the next `done`.

## Operation
- Input conditioning:
  - `ps2_clk_in` and `ps2_data_in` each pass through a 3-flop synchronizer.
  - A falling edge is detected when sync[2]=1 and sync[1]=0.
  - The data sample is taken from sync[1].
- Handshake:
  - A byte is accepted on a cycle where `tx_valid` and `tx_ready` are both high.
  - `tx_data` is captured into an internal register on that cycle. Later changes to `tx_data` have no effect on the transfer.
  - Parity is computed from the captured byte as odd parity, ~^byte.
- States:
  - **IDLE**
    - `tx_ready`=1, `busy`=0, both output enables 0.
    - Accepting a byte moves to INHIBIT.
  - **INHIBIT**
    - `ps2_clk_oe`=1, `ps2_data_oe`=0.
    - Held for `INHIBIT_CYCLES` cycles, then moves to REQUEST.
  - **REQUEST**
    - `ps2_clk_oe`=1, `ps2_data_oe`=1 (start bit) for exactly 1 cycle.
    - Then `ps2_clk_oe`=0, the bit counter is cleared, and the block moves to SEND.
  - **SEND**
    - On each detected falling edge n = 1..9, `ps2_data_oe` is set to the inverse of the bit being sent.
    - Edges 1..8 send data bits 0..7, LSB first. Edge 9 sends parity.
    - On edge 10, `ps2_data_oe`=0 (stop bit, line released) and the block moves to ACK.
  - **ACK**
    - On the next falling edge (edge 11), the data line is sampled: 0 means acked, 1 means no ack.
    - The result is latched and the block moves to WAIT_IDLE.
  - **WAIT_IDLE**
    - Waits until both synchronized lines are 1.
    - Then pulses `done` and loads `status` (00 or 10), returning to IDLE.
- Watchdog:
  - The counter is cleared on entry to REQUEST and on every detected falling edge.
  - It counts during SEND, ACK and WAIT_IDLE.
  - When it reaches `TIMEOUT_CYCLES`, both enables go to 0, `done` pulses, `status` becomes 01, and the block returns to IDLE. Timeout takes priority over a falling edge in the same cycle.
- `busy`=1 in every state except IDLE. `tx_ready` is exactly the inverse of `busy`.
- `tx_valid` while busy is ignored; no queueing.

## Timing
- Reset values (asynchronous, take effect immediately): state IDLE, `ps2_clk_oe`=0, `ps2_data_oe`=0, `tx_ready`=1, `busy`=0, `done`=0, `status`=00, counters 0.
- Reset mid-transfer releases both lines in the same cycle and aborts without a `done` pulse.
- All outputs are registered.
- Accept at cycle T:
  - `busy`=1 and `ps2_clk_oe`=1 at T+1.
  - `ps2_data_oe`=1 at T+1+`INHIBIT_CYCLES`.
  - `ps2_clk_oe`=0 one cycle later.
- Each data update is visible 1 cycle after the edge is detected, which is 3–4 cycles after the physical falling edge.
- `done` is high for exactly 1 cycle. `tx_ready` returns to 1 on the cycle after `done`.
- Widths:
  - Bit counter: 4 bits.
  - Inhibit counter: sized for `INHIBIT_CYCLES`.
  - Watchdog: sized for `TIMEOUT_CYCLES` (19 bits at default).

## Test plan
- Device model clocks at 12.5 kHz and pulls data low on edge 11; send 0xED → data line shows start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; `status`=00, single `done`.
- Send 0x01 → parity bit 0. `ps2_clk_oe` is high for exactly `INHIBIT_CYCLES`+1 cycles after accept.
- Device never clocks after REQUEST → `done` exactly `TIMEOUT_CYCLES` cycles after release, `status`=01, both enables 0.
- Device gives 11 edges but leaves data high on edge 11 → `status`=10.
- `tx_valid` pulsed with 0xFF mid-transfer of 0xED → `tx_ready`=0, 0xFF is not sent, the 0xED bitstream is unchanged.
- Async `reset` asserted between edges 5 and 6 → both enables 0 without waiting for a clock edge; after release, `tx_ready`=1, `status`=00.
